dbg_cmd_sysclk_bridge: RTL and testbench
========================================

# dbg_cmd_sysclk_bridge

Parametrised system-clock side of the Nios II JTAG debug path. It samples the virtual-JTAG update strobes (vs_uir, vs_udr) into the `clk` domain, latches the instruction register on each IR update, and queues each data-register update as a command `{ir, sr}` in a small FIFO. It drains commands through a valid/ready handshake and raises per-instruction take_action / take_no_action pulses. It generalises the fixed 2-bit-IR / 38-bit-SR sysclk decoder with configurable widths, command count, synchroniser depth, buffering and overflow reporting.

## Interface
Parameters:
- SR_W, 38, width of the debug shift register / command data
- IR_W, 2, instruction register width; NCMD = 2**IR_W
- ACT_BIT, 37, data bit that selects action (1) or no-action (0)
- SYNC_STAGES, 2, synchroniser flops per strobe (minimum 2)
- FIFO_DEPTH, 4, command queue entries (power of two, ≥2)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- ir_in  in  IR_W  tck-domain IR; quasi-static around vs_uir
- sr  in  SR_W  tck-domain shift register; quasi-static around vs_udr
- vs_uir  in  1  tck-domain IR-update level, held ≥ SYNC_STAGES+1 clk periods
- vs_udr  in  1  tck-domain DR-update level, held ≥ SYNC_STAGES+1 clk periods
- cmd_ready  in  1  consumer accepts the head command
- clr_overflow  in  1  clears the overflow flag
- cmd_valid  out  1  head command present
- cmd_ir  out  IR_W  head command instruction
- jdo  out  SR_W  head command data
- take_action  out  NCMD  one-hot pulse, ir==i and data[ACT_BIT]=1
- take_no_action  out  NCMD  one-hot pulse, ir==i and data[ACT_BIT]=0
- ir_update  out  1  one-cycle pulse when the IR latch loads
- overflow  out  1  sticky, a command was dropped
- fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries

## Operation
- Each strobe passes through an SYNC_STAGES-deep synchroniser followed by a rising-edge detector.
- An arming counter blocks edge detection until SYNC_STAGES+1 cycles after reset release. A strobe already high at reset release produces no event.
- On a uir edge: ir_q ← ir_in and ir_update pulses.
- On a udr edge: push {ir_q, sr}. When uir and udr edges occur in the same cycle, the push uses the old ir_q; ir_q updates in that same cycle.
- Queue handshake:
  - The head is shown on cmd_valid / cmd_ir / jdo.
  - Pop on cmd_valid & cmd_ready.
  - A push when full with no pop in the same cycle is dropped and sets overflow.
  - A push and pop in the same cycle while full are both accepted, and count stays at FIFO_DEPTH.
  - A push and pop in the same cycle while empty are impossible, because a push becomes visible only on the next cycle.
- On a pop, register one pulse on take_action[cmd_ir] or take_no_action[cmd_ir], chosen by jdo[ACT_BIT]. Exactly one bit of the two vectors is high for that cycle.
- overflow: clr_overflow takes priority over a new drop in the same cycle.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges from 0 to FIFO_DEPTH.

## Timing
- Reset values: all outputs 0, ir_q 0, pointers 0, synchroniser and edge flops 0, arming counter 0.
- The strobe is first sampled high at edge k. The edge is detected at k+SYNC_STAGES−1, the push occurs then, and cmd_valid is high from k+SYNC_STAGES.
- take_action / take_no_action pulse in the cycle after the handshake.
- ir_update pulses in the cycle after ir_q loads.
- fifo_count and overflow are registered and update one cycle after the push/pop edge.
- cmd_valid and data stay stable while cmd_ready is low.
- An asynchronous reset mid-operation empties the queue and clears the flags immediately. In-flight strobes are discarded by the arming counter.

## Structure
- Package dbg_bridge_pkg holds:
  - default constants SR_W_DEF=38, IR_W_DEF=2, ACT_BIT_DEF=37
  - localparam function for the count width
  - typedef dbg_cmd_t as packed {ir, data} parameterised via the package defaults
- Sub-module dbg_bridge_sync: synchroniser, edge detect and arming gate, with output `rise`. It is instantiated twice, once for uir and once for udr.
- The FIFO is a register array inline in the top; no RAM inference is required.

## Test plan
- Reset, then vs_uir high with ir_in=2'b01 -> ir_update pulses at sample+SYNC_STAGES; then vs_udr high with sr[37]=1 -> cmd_valid=1, cmd_ir=1, jdo matches; cmd_ready=1 -> take_action=4'b0010 for one cycle.
- Same sequence with sr[37]=0 and ir=2'b11 -> take_no_action=4'b1000; take_action stays 0.
- cmd_ready=0 with 5 udr events and FIFO_DEPTH=4 -> fifo_count=4 and overflow=1; drain gives the first 4 sr values in order; clr_overflow -> overflow=0.
- Full FIFO, cmd_ready=1 during a fifth push -> no drop, overflow=0, fifo_count stays 4.
- vs_udr held high through reset release -> no push, cmd_valid stays 0; the next low→high produces exactly one command.
- Simultaneous uir/udr edges, with ir_q=0 and ir_in=2 -> queued cmd_ir=0, ir_q=2 afterwards; reset asserted with 3 entries queued -> fifo_count=0 immediately.

Source files
------------

// File: rtl/dbg_bridge_pkg.sv
// ============================================================================
// Module   : dbg_bridge_pkg
// Purpose  : Shared defaults, sizing helper and command type for the debug
//            sysclk bridge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dbg_bridge_pkg;

    localparam int SR_W_DEF    = 38;
    localparam int IR_W_DEF    = 2;
    localparam int ACT_BIT_DEF = 37;

    // Occupancy counter must reach FIFO_DEPTH itself, hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic [IR_W_DEF-1:0] ir;
        logic [SR_W_DEF-1:0] data;
    } dbg_cmd_t;

endpackage

`default_nettype wire

// File: rtl/dbg_bridge_sync.sv
// ============================================================================
// Module   : dbg_bridge_sync
// Purpose  : Strobe synchroniser with rising-edge detect, gated until the
//            chain has settled after reset.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dbg_bridge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic strobe,
    output logic rise
);

    localparam int c_stages = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int c_arm_w  = $clog2(c_stages + 2);
    localparam logic [c_arm_w-1:0] c_arm_done = c_arm_w'(c_stages + 1);

    logic [c_stages-1:0] r_sync;
    logic                r_prev;
    logic [c_arm_w-1:0]  r_arm_cnt;
    logic                w_armed;

    assign w_armed = (r_arm_cnt == c_arm_done);

    // r_prev tracks the chain even while disarmed, so a level already high at
    // reset release is absorbed instead of reported as an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync    <= '0;
            r_prev    <= 1'b0;
            r_arm_cnt <= '0;
        end else begin
            r_sync <= {r_sync[c_stages-2:0], strobe};
            r_prev <= r_sync[c_stages-1];
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + 1'b1;
            end
        end
    end

    assign rise = r_sync[c_stages-1] & ~r_prev & w_armed;

endmodule

`default_nettype wire

// File: rtl/dbg_cmd_sysclk_bridge.sv
// ============================================================================
// Module   : dbg_cmd_sysclk_bridge
// Purpose  : System-clock side of the JTAG debug path: IR latch, command
//            queue and per-instruction action pulses.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dbg_cmd_sysclk_bridge
    import dbg_bridge_pkg::*;
#(
    parameter int SR_W        = SR_W_DEF,
    parameter int IR_W        = IR_W_DEF,
    parameter int ACT_BIT     = ACT_BIT_DEF,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [IR_W-1:0]                  ir_in,
    input  logic [SR_W-1:0]                  sr,
    input  logic                             vs_uir,
    input  logic                             vs_udr,
    input  logic                             cmd_ready,
    input  logic                             clr_overflow,
    output logic                             cmd_valid,
    output logic [IR_W-1:0]                  cmd_ir,
    output logic [SR_W-1:0]                  jdo,
    output logic [(2**IR_W)-1:0]             take_action,
    output logic [(2**IR_W)-1:0]             take_no_action,
    output logic                             ir_update,
    output logic                             overflow,
    output logic [cnt_width(FIFO_DEPTH)-1:0] fifo_count
);

    localparam int c_ncmd  = 2**IR_W;
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = cnt_width(FIFO_DEPTH);
    localparam int c_cmd_w = IR_W + SR_W;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(FIFO_DEPTH);
    localparam logic [c_ncmd-1:0]  c_one      = c_ncmd'(1);

    logic [c_cmd_w-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [IR_W-1:0]     r_ir_q;
    logic                r_ir_update;
    logic                r_overflow;
    logic [c_ncmd-1:0]   r_take_action;
    logic [c_ncmd-1:0]   r_take_no_action;

    logic                w_uir_rise;
    logic                w_udr_rise;
    logic                w_full;
    logic                w_pop;
    logic                w_wr_en;
    logic                w_drop;
    logic [c_ncmd-1:0]   w_sel;

    dbg_bridge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_uir),
        .rise    (w_uir_rise)
    );

    dbg_bridge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_udr_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .strobe  (vs_udr),
        .rise    (w_udr_rise)
    );

    assign cmd_valid       = (r_count != '0);
    assign {cmd_ir, jdo}   = r_mem[r_rd_ptr];
    assign fifo_count      = r_count;
    assign overflow        = r_overflow;
    assign ir_update       = r_ir_update;
    assign take_action     = r_take_action;
    assign take_no_action  = r_take_no_action;

    assign w_full  = (r_count == c_full_cnt);
    assign w_pop   = cmd_valid & cmd_ready;
    // When full, a simultaneous pop frees the head slot, which is exactly
    // where the write pointer points, so the push still fits.
    assign w_wr_en = w_udr_rise & (~w_full | w_pop);
    assign w_drop  = w_udr_rise & w_full & ~w_pop;
    assign w_sel   = c_one << cmd_ir;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
            r_ir_q           <= '0;
            r_ir_update      <= 1'b0;
            r_overflow       <= 1'b0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_ir_update <= w_uir_rise;
            if (w_uir_rise) begin
                r_ir_q <= ir_in;
            end

            // Uses the pre-update r_ir_q when both strobes land together.
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= {r_ir_q, sr};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (clr_overflow) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end

            r_take_action    <= (w_pop &  jdo[ACT_BIT]) ? w_sel : '0;
            r_take_no_action <= (w_pop & ~jdo[ACT_BIT]) ? w_sel : '0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dbg_cmd_sysclk_bridge.sv
// ============================================================================
// Module   : tb_dbg_cmd_sysclk_bridge
// Purpose  : Directed self-checking bench for dbg_cmd_sysclk_bridge.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dbg_cmd_sysclk_bridge;
    import dbg_bridge_pkg::*;

    logic        clk;
    logic        reset_n;
    logic [1:0]  ir_in;
    logic [37:0] sr;
    logic        vs_uir;
    logic        vs_udr;
    logic        cmd_ready;
    logic        clr_overflow;
    logic        cmd_valid;
    logic [1:0]  cmd_ir;
    logic [37:0] jdo;
    logic [3:0]  take_action;
    logic [3:0]  take_no_action;
    logic        ir_update;
    logic        overflow;
    logic [2:0]  fifo_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [37:0] vals [5];
    dbg_cmd_t    exp_cmd;

    dbg_cmd_sysclk_bridge dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ir_in          (ir_in),
        .sr             (sr),
        .vs_uir         (vs_uir),
        .vs_udr         (vs_udr),
        .cmd_ready      (cmd_ready),
        .clr_overflow   (clr_overflow),
        .cmd_valid      (cmd_valid),
        .cmd_ir         (cmd_ir),
        .jdo            (jdo),
        .take_action    (take_action),
        .take_no_action (take_no_action),
        .ir_update      (ir_update),
        .overflow       (overflow),
        .fifo_count     (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic uir_event(input logic [1:0] ir);
        ir_in  = ir;
        vs_uir = 1'b1;
        tick(4);
        vs_uir = 1'b0;
        tick(4);
    endtask

    task automatic udr_event(input logic [37:0] v);
        sr     = v;
        vs_udr = 1'b1;
        tick(4);
        vs_udr = 1'b0;
        tick(4);
    endtask

    task automatic pop_one();
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; ir_in = '0; sr = '0; vs_uir = 1'b0; vs_udr = 1'b0;
        cmd_ready = 1'b0; clr_overflow = 1'b0;
        vals[0] = 38'h20_0000_0011; vals[1] = 38'h00_0000_0022;
        vals[2] = 38'h2A_5A5A_0033; vals[3] = 38'h15_A5A5_0044;
        vals[4] = 38'h3F_FFFF_0055;
        tick(3);
        reset_n = 1'b1;
        tick(5);

        // Reset state
        check("rst_valid", cmd_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_act", {take_action, take_no_action}, 0);
        check("rst_jdo", jdo, 0);

        // IR update timing: pulse only in the third sampled cycle
        ir_in = 2'b01; vs_uir = 1'b1;
        tick(2); check("iru_early", ir_update, 0);
        tick(1); check("iru_pulse", ir_update, 1);
        tick(1); check("iru_end", ir_update, 0);
        vs_uir = 1'b0; tick(4);

        // Action command on ir=1
        exp_cmd.ir = 2'b01; exp_cmd.data = 38'h20_0000_0ABC;
        sr = exp_cmd.data; vs_udr = 1'b1;
        tick(2); check("cmd_lat", cmd_valid, 0);
        tick(1); check("cmd_valid", cmd_valid, 1);
        check("cmd_word", {cmd_ir, jdo}, exp_cmd);
        check("cmd_count", fifo_count, 1);
        vs_udr = 1'b0; tick(4);
        check("cmd_hold", {cmd_valid, cmd_ir, jdo}, {1'b1, exp_cmd});
        pop_one();
        check("act_pulse", take_action, 4'b0010);
        check("act_noact", take_no_action, 4'b0000);
        check("act_empty", cmd_valid, 0);
        tick(1);
        check("act_clear", {take_action, take_no_action}, 0);

        // No-action command on ir=3
        uir_event(2'b11);
        udr_event(38'h00_0000_0123);
        check("na_ir", cmd_ir, 3);
        check("na_jdo", jdo, 38'h00_0000_0123);
        pop_one();
        check("na_pulse", take_no_action, 4'b1000);
        check("na_act0", take_action, 4'b0000);
        tick(1);
        check("na_clear", take_no_action, 0);

        // Overflow: five pushes into a four-deep queue
        for (int i = 0; i < 5; i++) udr_event(vals[i]);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        for (int i = 0; i < 4; i++) begin
            check("ovf_drain", {cmd_ir, jdo}, {2'b11, vals[i]});
            pop_one();
        end
        check("ovf_empty", cmd_valid, 0);
        check("ovf_sticky", overflow, 1);
        clr_overflow = 1'b1; tick(1); clr_overflow = 1'b0;
        check("ovf_clr", overflow, 0);
        tick(2);

        // Full queue with simultaneous push and pop
        for (int i = 0; i < 4; i++) udr_event(vals[i]);
        check("full_count", fifo_count, 4);
        sr = vals[4]; vs_udr = 1'b1;
        tick(2);
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        check("pp_count", fifo_count, 4);
        check("pp_ovf", overflow, 0);
        vs_udr = 1'b0; tick(4);
        for (int i = 1; i < 5; i++) begin
            check("pp_drain", jdo, vals[i]);
            pop_one();
        end
        check("pp_empty", fifo_count, 0);

        // Strobe held high through reset release
        vs_udr = 1'b1; sr = 38'h00_1234_5678;
        reset_n = 1'b0; tick(2); reset_n = 1'b1;
        tick(8);
        check("held_valid", cmd_valid, 0);
        check("held_count", fifo_count, 0);
        vs_udr = 1'b0; tick(4);
        udr_event(38'h00_1234_5678);
        check("held_one", fifo_count, 1);
        check("held_word", {cmd_ir, jdo}, {2'b00, 38'h00_1234_5678});
        pop_one();
        tick(1);

        // Simultaneous uir/udr: command keeps old ir, ir_q takes new one
        ir_in = 2'b10; sr = 38'h0A_BCDE_F012;
        vs_uir = 1'b1; vs_udr = 1'b1;
        tick(4);
        vs_uir = 1'b0; vs_udr = 1'b0;
        tick(4);
        check("sim_ir_old", {cmd_ir, jdo}, {2'b00, 38'h0A_BCDE_F012});
        udr_event(38'h00_0000_0777);
        udr_event(38'h00_0000_0888);
        check("sim_count3", fifo_count, 3);
        pop_one();
        check("sim_ir_new", {cmd_ir, jdo}, {2'b10, 38'h00_0000_0777});
        udr_event(38'h00_0000_0999);
        check("pre_rst_cnt", fifo_count, 3);

        // Asynchronous reset clears queue immediately
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_count", fifo_count, 0);
        check("arst_valid", cmd_valid, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
